div_sched: RTL and testbench

- Multi-cycle divide sequencer for the RV32M DIV/DIVU/REM/REMU path. The decoder marks these instructions as non-writing; this block completes them later.
- ex hands off operands, funct3 and the destination register. The block runs a 32-step restoring shift-subtract FSM and returns one result with a single-cycle ready pulse, so ex can write back and release the pipeline hold.
- A jump or flush aborts an in-flight operation.

---
 rtl/div_sched.sv | 136 +++++++++++++
 tb/tb_div_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with flush abort.
// Optional macro DIV_ZERO_FASTPATH_EN: divide-by-zero bypasses the 32-step loop.
module div_sched #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic [2:0]       op_i,
  input  logic [4:0]       reg_waddr_i,
  input  logic             flush_i,
  output logic [XLEN-1:0]  result_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic [4:0]       reg_waddr_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t           state, state_nxt;
  logic [XLEN-1:0]  dvd_r, dvs_r, quo_r, rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_rem_r, dz_r, qsign_r, rsign_r;

  logic             accept, signed_op, div_zero, d_neg, v_neg, fast_dz, sub_ok;
  logic [XLEN-1:0]  dvd_mag, dvs_mag, rem_dif, quo_fin, rem_fin;
  logic [XLEN:0]    rem_sh;

`ifdef DIV_ZERO_FASTPATH_EN
  assign fast_dz = dz_r;
`else
  assign fast_dz = 1'b0;
`endif

  // funct3 0xx belongs to the multiplier and is never accepted here.
  assign accept    = (state == S_IDLE) && start_i && !flush_i && op_i[2];
  assign signed_op = ~op_i[0];
  assign div_zero  = (divisor_i == '0);
  assign d_neg     = signed_op & dividend_i[XLEN-1] & ~div_zero;
  assign v_neg     = signed_op & divisor_i[XLEN-1];
  assign dvd_mag   = d_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign dvs_mag   = v_neg ? (~divisor_i + 1'b1) : divisor_i;

  // The low XLEN bits of the difference are exact whenever the subtract is taken.
  assign rem_sh  = {rem_r, dvd_r[XLEN-1]};
  assign sub_ok  = (rem_sh >= {1'b0, dvs_r});
  assign rem_dif = rem_sh[XLEN-1:0] - dvs_r;
  assign quo_fin = (qsign_r & ~dz_r) ? (~quo_r + 1'b1) : quo_r;
  assign rem_fin = (rsign_r & ~dz_r) ? (~rem_r + 1'b1) : rem_r;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CALC;
      S_CALC: begin
        if (flush_i)                         state_nxt = S_IDLE;
        else if (fast_dz || cnt_r == LAST)   state_nxt = S_END;
      end
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears the whole datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_o    <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      reg_waddr_o <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      is_rem_r    <= 1'b0;
      dz_r        <= 1'b0;
      qsign_r     <= 1'b0;
      rsign_r     <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy_o      <= 1'b1;
            reg_waddr_o <= reg_waddr_i;
            is_rem_r    <= op_i[1];
            dz_r        <= div_zero;
            qsign_r     <= d_neg ^ v_neg;
            rsign_r     <= d_neg;
            dvd_r       <= dvd_mag;
            dvs_r       <= dvs_mag;
            cnt_r       <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
            quo_r       <= div_zero ? '1 : '0;
            rem_r       <= div_zero ? dividend_i : '0;
`else
            quo_r       <= '0;
            rem_r       <= '0;
`endif
          end
        end
        S_CALC: begin
          if (flush_i) begin
            busy_o <= 1'b0;
          end else if (!fast_dz) begin
            rem_r <= sub_ok ? rem_dif : rem_sh[XLEN-1:0];
            quo_r <= {quo_r[XLEN-2:0], sub_ok};
            dvd_r <= {dvd_r[XLEN-2:0], 1'b0};
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_END: begin
          busy_o <= 1'b0;
          if (!flush_i) begin
            result_o <= is_rem_r ? rem_fin : quo_fin;
            ready_o  <= 1'b1;
          end
        end
        default: busy_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: directed vectors, monitor checks result, rd and latency.
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [2:0]  op_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
  localparam int LAT = 33;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  div_sched #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dividend_i(dividend_i),
    .divisor_i(divisor_i), .op_i(op_i), .reg_waddr_i(reg_waddr_i),
    .flush_i(flush_i), .result_o(result_o), .ready_o(ready_o),
    .busy_o(busy_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic        ready_q = 1'b0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o) begin
      if (sb.size() == 0) begin
        check("spurious_ready", {31'b0, ready_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("rd_out", {27'b0, reg_waddr_o}, {27'b0, e.rd});
        check("latency", cyc, e.due);
      end
      check("ready_width", {31'b0, ready_q}, 32'd0);
    end
    ready_q = ready_o;
  end

  // Called at a negedge; the request is accepted on the next posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int lat,
                       input bit push);
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    if (push) begin
      sb.push_back('{res: exp, rd: rd, due: cyc + lat});
      last_res = exp;
    end
    check("busy_after_accept", {31'b0, busy_o}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
    check("busy_idle", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    issue(op, a, b, rd, exp, lat, 1'b1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  int acc;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", result_o, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_rd", {27'b0, reg_waddr_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run(OP_DIVU, 32'd100,      32'd7,          5'd1,  32'd14,       LAT);
    run(OP_DIV,  32'hFFFFFFF9, 32'd2,          5'd2,  32'hFFFFFFFD, LAT);
    run(OP_REM,  32'hFFFFFFF9, 32'd2,          5'd3,  32'hFFFFFFFF, LAT);
    run(OP_REMU, 32'hFFFFFFFF, 32'd16,         5'd4,  32'h0000000F, LAT);
    run(OP_DIV,  32'd7,        32'hFFFFFFFE,   5'd5,  32'hFFFFFFFD, LAT);
    run(OP_REM,  32'd7,        32'hFFFFFFFE,   5'd6,  32'd1,        LAT);
    run(OP_DIV,  32'h80000000, 32'hFFFFFFFF,   5'd7,  32'h80000000, LAT);
    run(OP_REM,  32'h80000000, 32'hFFFFFFFF,   5'd8,  32'd0,        LAT);
    run(OP_DIVU, 32'hFFFFFFFF, 32'd1,          5'd9,  32'hFFFFFFFF, LAT);
    run(OP_DIVU, 32'd3,        32'hFFFFFFFF,   5'd10, 32'd0,        LAT);
    run(OP_REMU, 32'd3,        32'hFFFFFFFF,   5'd11, 32'd3,        LAT);
    run(OP_DIVU, 32'd5,        32'd0,          5'd12, 32'hFFFFFFFF, ZLAT);
    run(OP_REM,  32'd5,        32'd0,          5'd13, 32'd5,        ZLAT);
    run(OP_DIV,  32'hFFFFFFFB, 32'd0,          5'd14, 32'hFFFFFFFF, ZLAT);
    run(OP_REM,  32'hFFFFFFFB, 32'd0,          5'd15, 32'hFFFFFFFB, ZLAT);

    // Flush mid-calculation, then restart on the very next cycle.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd20, 32'd0, LAT, 1'b0);
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", {31'b0, busy_o}, 32'd0);
    check("flush_ready", {31'b0, ready_o}, 32'd0);
    check("flush_result_held", result_o, last_res);
    run(OP_DIVU, 32'd1000, 32'd3, 5'd21, 32'd333, LAT);

    // Flush together with start in IDLE is not accepted.
    op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3; reg_waddr_i = 5'd22;
    start_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", {31'b0, busy_o}, 32'd0);
    check("flush_start_rd", {27'b0, reg_waddr_o}, 32'd21);

    // Synchronous reset mid-CALC.
    issue(OP_DIV, 32'd12345, 32'hFFFFFFF9, 5'd23, 32'd0, LAT, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_result", result_o, 32'd0);
    check("midrst_ready", {31'b0, ready_o}, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    check("midrst_rd", {27'b0, reg_waddr_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run(OP_DIVU, 32'd50, 32'd5, 5'd24, 32'd10, LAT);

    // A start pulse while busy is ignored.
    issue(OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, LAT, 1'b1);
    repeat (5) @(negedge clk);
    op_i = OP_REMU; dividend_i = 32'd9; divisor_i = 32'd2; reg_waddr_i = 5'd17;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_start_rd", {27'b0, reg_waddr_o}, 32'd3);
    repeat (10) @(negedge clk);
    check("busy_mid", {31'b0, busy_o}, 32'd1);
    wait_idle();

    // start_i held high: ignored on the END edge, accepted on the next IDLE cycle.
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd4;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    sb.push_back('{res: 32'd14, rd: 5'd4, due: acc + LAT});
    op_i = OP_DIV; dividend_i = 32'hFFFFFFF9; divisor_i = 32'd2; reg_waddr_i = 5'd5;
    sb.push_back('{res: 32'hFFFFFFFD, rd: 5'd5, due: acc + LAT + 1 + LAT});
    repeat (LAT + 1) @(negedge clk);
    start_i = 1'b0;
    check("hold_reaccept_busy", {31'b0, busy_o}, 32'd1);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
